// File: rtl/tick_period_meter.sv
`default_nettype none
// ============================================================================
// Module      : tick_period_meter
// Description : Measures the spacing, in clk cycles, between rising edges of
//               a possibly asynchronous tick input. The input is synchronized
//               and edge-detected internally. A timeout flags a stalled source.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_period_meter #(
  parameter int COUNT_WIDTH    = 32,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 200_000_000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   tickIn,
  output logic [COUNT_WIDTH-1:0] period,
  output logic                   periodValid,
  output logic                   timeout
);

  localparam logic [COUNT_WIDTH-1:0] TIMEOUT_VAL = COUNT_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [COUNT_WIDTH-1:0] ONE         = COUNT_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0] ZERO        = '0;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_MEASURE = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   tick_edge;

  state_t                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [COUNT_WIDTH-1:0] period_q, period_d;
  logic                   valid_q, valid_d;
  logic                   timeout_q, timeout_d;

  // Synchronizer chain plus one flop holding the previous synchronized level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], tickIn};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // A held-high input produces a single edge because prev follows synced.
  assign tick_edge = sync_q[SYNC_STAGES-1] & ~prev_q;

  // State, counter and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      count_q   <= ZERO;
      period_q  <= ZERO;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state logic: enable low overrides everything, and an edge takes
  // priority over the timeout threshold in the same cycle.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    period_d  = period_q;
    valid_d   = 1'b0;
    timeout_d = timeout_q;
    if (!enable) begin
      state_d   = S_IDLE;
      count_d   = ZERO;
      timeout_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          count_d = ZERO;
          state_d = S_ARMED;
        end
        S_ARMED: begin
          // First edge only starts the reference; timeout stays as it was.
          if (tick_edge) begin
            state_d = S_MEASURE;
            count_d = ONE;
          end
        end
        S_MEASURE: begin
          if (tick_edge) begin
            period_d  = count_q;
            valid_d   = 1'b1;
            timeout_d = 1'b0;
            count_d   = ONE;
          end else if (count_q == TIMEOUT_VAL) begin
            // Threshold reached before overflow: flag and wait for a new reference.
            timeout_d = 1'b1;
            count_d   = ZERO;
            state_d   = S_ARMED;
          end else begin
            count_d = count_q + ONE;
          end
        end
        default: begin
          state_d = S_IDLE;
          count_d = ZERO;
        end
      endcase
    end
  end

  assign period      = period_q;
  assign periodValid = valid_q;
  assign timeout     = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_tick_period_meter.sv
`default_nettype none
// ============================================================================
// Module      : tb_tick_period_meter
// Description : Self-checking bench for tick_period_meter. A timestamp-based
//               reference model is compared with the DUT on every falling
//               clock edge; directed scenarios add literal expectations and a
//               randomized pulse train follows.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tick_period_meter;

  localparam int CW   = 8;
  localparam int SYNC = 2;
  localparam int TO   = 20;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          tickIn;
  logic [CW-1:0] period;
  logic          periodValid;
  logic          timeout;

  tick_period_meter #(
    .COUNT_WIDTH   (CW),
    .SYNC_STAGES   (SYNC),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .tickIn     (tickIn),
    .period     (period),
    .periodValid(periodValid),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int pv_seen  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // hist[k] is the tickIn value sampled k+1 rising clk edges ago. A rising
  // input becomes visible to the measurement logic SYNC+1 edges after it is
  // first sampled high.
  int          t = 0;
  bit [15:0]   hist = '0;
  bit          m_on = 1'b0;       // enabled for at least one cycle
  bit          m_have_ref = 1'b0; // a reference edge timestamp exists
  int          t0 = 0;
  bit [CW-1:0] m_period = '0;
  bit          m_pv = 1'b0;
  bit          m_to = 1'b0;
  wire         m_edge = hist[SYNC-1] & ~hist[SYNC];

  always @(posedge clk) t <= t + 1;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist       <= '0;
      m_on       <= 1'b0;
      m_have_ref <= 1'b0;
      t0         <= 0;
      m_period   <= '0;
      m_pv       <= 1'b0;
      m_to       <= 1'b0;
    end else begin
      hist <= {hist[14:0], tickIn};
      m_pv <= 1'b0;
      if (!enable) begin
        m_on       <= 1'b0;
        m_have_ref <= 1'b0;
        m_to       <= 1'b0;
      end else if (!m_on) begin
        m_on <= 1'b1;
      end else if (!m_have_ref) begin
        if (m_edge) begin
          m_have_ref <= 1'b1;
          t0         <= t;
        end
      end else if (m_edge) begin
        m_period <= CW'(t - t0);
        m_pv     <= 1'b1;
        m_to     <= 1'b0;
        t0       <= t;
      end else if (t - t0 == TO) begin
        m_to       <= 1'b1;
        m_have_ref <= 1'b0;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    check("period", period, m_period);
    check("periodValid", periodValid, m_pv);
    check("timeout", timeout, m_to);
    if (periodValid === 1'b1) pv_seen++;
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic pulses(input int n, input int spacing, input int width);
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c < spacing; c++) begin
        tickIn = (c < width);
        step();
      end
    end
  endtask

  int p0;

  initial begin
    rst    = 1'b0;
    enable = 1'b0;
    tickIn = 1'b0;

    // Held in reset with the input toggling: outputs stay clear.
    enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tickIn = i[0];
      step();
    end
    check("rst_period", period, 0);
    check("rst_timeout", timeout, 0);
    tickIn = 1'b0;
    enable = 1'b0;
    step();
    rst = 1'b1;
    step();

    // Spacing 10: first pulse only arms.
    enable = 1'b1;
    p0 = pv_seen;
    pulses(6, 10, 1);
    check("s2_count", pv_seen - p0, 5);
    check("s2_period", period, 10);
    check("s2_timeout", timeout, 0);

    // Spacing 5, narrow pulses then 3-cycle-wide pulses.
    p0 = pv_seen;
    pulses(5, 5, 1);
    check("s3_count", pv_seen - p0, 5);
    check("s3_period", period, 5);
    p0 = pv_seen;
    pulses(4, 5, 3);
    check("s3_wide_count", pv_seen - p0, 4);
    check("s3_wide_period", period, 5);

    // Stall: timeout rises, period kept.
    p0 = pv_seen;
    repeat (24) step();
    check("s4_timeout", timeout, 1);
    check("s4_period", period, 5);
    check("s4_count", pv_seen - p0, 0);
    pulses(1, 7, 1);
    check("s4_rearm_timeout", timeout, 1);
    check("s4_rearm_count", pv_seen - p0, 0);
    pulses(2, 7, 1);
    check("s4_restart_count", pv_seen - p0, 2);
    check("s4_restart_period", period, 7);
    check("s4_restart_timeout", timeout, 0);

    // One-cycle enable drop mid-measurement.
    enable = 1'b0;
    step();
    enable = 1'b1;
    p0 = pv_seen;
    pulses(1, 7, 1);
    check("s5_first_count", pv_seen - p0, 0);
    pulses(2, 7, 1);
    check("s5_count", pv_seen - p0, 2);
    check("s5_period", period, 7);

    // Pulses while disabled are ignored.
    enable = 1'b0;
    p0 = pv_seen;
    pulses(2, 6, 1);
    check("s5_dis_count", pv_seen - p0, 0);
    check("s5_dis_period", period, 7);
    enable = 1'b1;
    pulses(3, 6, 1);
    check("s5_reen_count", pv_seen - p0, 2);
    check("s5_reen_period", period, 6);

    // Spacing equal to the timeout threshold: the edge wins.
    p0 = pv_seen;
    pulses(4, 20, 1);
    check("s6_count", pv_seen - p0, 4);
    check("s6_period", period, 20);
    check("s6_timeout", timeout, 0);

    // Asynchronous reset between clock edges.
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("async_period", period, 0);
    check("async_valid", periodValid, 0);
    check("async_timeout", timeout, 0);
    step();
    step();
    rst = 1'b1;
    p0 = pv_seen;
    pulses(2, 8, 1);
    check("post_rst_count", pv_seen - p0, 1);
    check("post_rst_period", period, 8);

    // Randomized pulse train with occasional enable drops and stalls.
    for (int i = 0; i < 400; i++) begin
      int sp;
      int w;
      sp = $urandom_range(24, 2);
      w  = $urandom_range(sp - 1, 1);
      if ($urandom_range(15, 0) == 0) begin
        enable = 1'b0;
        step();
        enable = 1'b1;
      end
      if ($urandom_range(30, 0) == 0) repeat (25) step();
      pulses(1, sp, w);
    end

    tickIn = 1'b0;
    repeat (5) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
